midi_voice_alloc: RTL and testbench



---
 rtl/midi_voice_alloc_pkg.sv | 27 ++
 rtl/midi_voice_alloc_voice_slot_select.sv | 40 ++++
 rtl/midi_voice_alloc.sv | 162 ++++++++++++++++
 tb/tb_midi_voice_alloc.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/midi_voice_alloc_pkg.sv
// Shared types and constants for the MIDI voice allocator.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF         = 4'h8;
  localparam logic [3:0] NOTE_ON          = 4'h9;
  localparam logic [3:0] CTRL_CHANGE      = 4'hB;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef struct packed {
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
  } voice_slot_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECIDE,
    ST_COMMIT,
    ST_HOLDOFF
  } alloc_state_t;

  // Burst word layout: [15:8] note, [7:0] velocity, MSBs always zero.
  function automatic logic [15:0] slot_word(input voice_slot_t s);
    return {1'b0, s.note, 1'b0, s.vel};
  endfunction

endpackage

// File: rtl/midi_voice_alloc_voice_slot_select.sv
// Combinational slot search: note match, lowest free slot and steal target.
module voice_slot_select
  import midi_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = 5,
  parameter int unsigned FIRST_SLOT = 1,
  localparam int unsigned IW        = $clog2(NUM_SLOTS)
) (
  input  voice_slot_t [NUM_SLOTS-1:0] slots_i,
  input  logic [6:0]                  note_i,
  input  logic [IW-1:0]               steal_ptr_i,
  output logic                        match_hit_o,
  output logic [IW-1:0]               match_idx_o,
  output logic                        free_hit_o,
  output logic [IW-1:0]               free_idx_o,
  output logic [IW-1:0]               steal_idx_o
);

  logic unused_slot0;
  assign unused_slot0 = ^slots_i[0];

  always_comb begin
    match_hit_o = 1'b0;
    match_idx_o = '0;
    free_hit_o  = 1'b0;
    free_idx_o  = '0;
    for (int unsigned i = FIRST_SLOT; i < NUM_SLOTS; i++) begin
      if (!match_hit_o && slots_i[i].on && (slots_i[i].note == note_i)) begin
        match_hit_o = 1'b1;
        match_idx_o = IW'(i);
      end
      if (!free_hit_o && !slots_i[i].on) begin
        free_hit_o = 1'b1;
        free_idx_o = IW'(i);
      end
    end
    steal_idx_o = steal_ptr_i;
  end

endmodule

// File: rtl/midi_voice_alloc.sv
// MIDI voice allocator: maps note-on/off and all-notes-off onto a fixed slot
// array and publishes it with a one-cycle change strobe.
module midi_voice_alloc
  import midi_pkg::*;
#(
  parameter int unsigned NUM_SLOTS      = 5,
  parameter int unsigned FIRST_SLOT     = 1,
  parameter int unsigned HOLDOFF_CYCLES = 32,
  parameter bit          OMNI           = 1'b1,
  parameter logic [3:0]  CHANNEL        = 4'd0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     msg_valid_in,
  output logic                     msg_ready_out,
  input  logic [7:0]               msg_status_in,
  input  logic [7:0]               msg_data1_in,
  input  logic [7:0]               msg_data2_in,
  output logic [NUM_SLOTS-1:0]     on_array_out,
  output logic [16*NUM_SLOTS-1:0]  midi_burst_data_out,
  output logic                     midi_burst_change_out,
  output logic [2:0]               active_count_out
);

  localparam int unsigned IW = $clog2(NUM_SLOTS);
  localparam int unsigned CW = $clog2(HOLDOFF_CYCLES + 1);

  alloc_state_t                state_q, state_d;
  voice_slot_t [NUM_SLOTS-1:0] slots_q, slots_d;
  logic [IW-1:0]               ptr_q, ptr_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        chg_q, chg_d;
  logic [2:0]                  count_q, count_d;

  logic [3:0] kind_q, chan_q;
  logic [6:0] note_q, vel_q;

  logic          accept;
  logic          match_hit, free_hit;
  logic [IW-1:0] match_idx, free_idx, steal_idx;
  logic          chan_ok, is_on, is_off, is_anf, any_on;

  logic unused_msb;
  assign unused_msb = msg_data1_in[7] ^ msg_data2_in[7];

  assign msg_ready_out = (state_q == ST_IDLE) && !rst_in;
  assign accept        = msg_valid_in && msg_ready_out;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      kind_q <= '0;
      chan_q <= '0;
      note_q <= '0;
      vel_q  <= '0;
    end else if (accept) begin
      kind_q <= msg_status_in[7:4];
      chan_q <= msg_status_in[3:0];
      note_q <= msg_data1_in[6:0];
      vel_q  <= msg_data2_in[6:0];
    end
  end

  voice_slot_select #(
    .NUM_SLOTS (NUM_SLOTS),
    .FIRST_SLOT(FIRST_SLOT)
  ) u_select (
    .slots_i    (slots_q),
    .note_i     (note_q),
    .steal_ptr_i(ptr_q),
    .match_hit_o(match_hit),
    .match_idx_o(match_idx),
    .free_hit_o (free_hit),
    .free_idx_o (free_idx),
    .steal_idx_o(steal_idx)
  );

  // Velocity is checked after masking, so a 0x80 velocity byte acts as note-off.
  assign chan_ok = OMNI || (chan_q == CHANNEL);
  assign is_on   = chan_ok && (kind_q == NOTE_ON) && (vel_q != 7'd0);
  assign is_off  = chan_ok && ((kind_q == NOTE_OFF) || ((kind_q == NOTE_ON) && (vel_q == 7'd0)));
  assign is_anf  = chan_ok && (kind_q == CTRL_CHANGE) && (note_q == CC_ALL_NOTES_OFF);

  always_comb begin
    any_on = 1'b0;
    for (int unsigned i = FIRST_SLOT; i < NUM_SLOTS; i++) any_on = any_on | slots_q[i].on;
  end

  always_comb begin
    state_d = state_q;
    slots_d = slots_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    chg_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_DECIDE;
      ST_DECIDE: begin
        state_d = ST_IDLE;
        if (is_on) begin
          state_d = ST_COMMIT;
          if (match_hit) begin
            slots_d[match_idx].vel = vel_q;
          end else if (free_hit) begin
            slots_d[free_idx] = '{on: 1'b1, note: note_q, vel: vel_q};
          end else begin
            slots_d[steal_idx] = '{on: 1'b1, note: note_q, vel: vel_q};
            ptr_d = (ptr_q == IW'(NUM_SLOTS - 1)) ? IW'(FIRST_SLOT) : ptr_q + 1'b1;
          end
        end else if (is_off && match_hit) begin
          state_d            = ST_COMMIT;
          slots_d[match_idx] = '0;
        end else if (is_anf && any_on) begin
          state_d = ST_COMMIT;
          slots_d = '0;
        end
        chg_d = (state_d == ST_COMMIT);
      end
      ST_COMMIT: begin
        state_d = ST_HOLDOFF;
        cnt_d   = '0;
      end
      ST_HOLDOFF: begin
        if (cnt_q == CW'(HOLDOFF_CYCLES - 1)) state_d = ST_IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    slots_d[0] = '0;
    count_d = '0;
    for (int unsigned i = FIRST_SLOT; i < NUM_SLOTS; i++) count_d = count_d + 3'(slots_d[i].on);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      slots_q <= '0;
      ptr_q   <= IW'(FIRST_SLOT);
      cnt_q   <= '0;
      chg_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      slots_q <= slots_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      chg_q   <= chg_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    on_array_out        = '0;
    midi_burst_data_out = '0;
    for (int unsigned i = FIRST_SLOT; i < NUM_SLOTS; i++) begin
      on_array_out[i]                 = slots_q[i].on;
      midi_burst_data_out[16*i +: 16] = slot_word(slots_q[i]);
    end
  end

  assign midi_burst_change_out = chg_q;
  assign active_count_out      = count_q;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Table-driven bench for midi_voice_alloc with a strobe scoreboard.
module tb_midi_voice_alloc;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid0, valid1;
  logic [7:0]  st, d1, d2;
  logic        rdy0, rdy1, chg0, chg1;
  logic [4:0]  on0, on1;
  logic [79:0] data0, data1;
  logic [2:0]  cnt0, cnt1;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  midi_voice_alloc #(.NUM_SLOTS(5), .FIRST_SLOT(1), .HOLDOFF_CYCLES(32), .OMNI(1'b1), .CHANNEL(4'd0)) dut0 (
    .clk_in(clk), .rst_in(rst), .msg_valid_in(valid0), .msg_ready_out(rdy0),
    .msg_status_in(st), .msg_data1_in(d1), .msg_data2_in(d2),
    .on_array_out(on0), .midi_burst_data_out(data0),
    .midi_burst_change_out(chg0), .active_count_out(cnt0));

  midi_voice_alloc #(.NUM_SLOTS(5), .FIRST_SLOT(1), .HOLDOFF_CYCLES(32), .OMNI(1'b0), .CHANNEL(4'd2)) dut1 (
    .clk_in(clk), .rst_in(rst), .msg_valid_in(valid1), .msg_ready_out(rdy1),
    .msg_status_in(st), .msg_data1_in(d1), .msg_data2_in(d2),
    .on_array_out(on1), .midi_burst_data_out(data1),
    .midi_burst_change_out(chg1), .active_count_out(cnt1));

  typedef struct {
    bit          dut;
    logic [7:0]  st, d1, d2;
    bit          change;
    bit          nowait;
    logic [4:0]  on;
    logic [79:0] data;
    logic [2:0]  cnt;
  } vec_t;

  typedef struct {
    bit          dut;
    logic [4:0]  on;
    logic [79:0] data;
    logic [2:0]  cnt;
    int unsigned at;
  } exp_t;

  vec_t vt[31];
  exp_t sbq[$];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic get_rdy(input bit d);
    return d ? rdy1 : rdy0;
  endfunction

  task automatic wait_to(input int unsigned t);
    do @(negedge clk); while (cyc < t);
  endtask

  always @(negedge clk) begin
    if (chg0 === 1'b1 || chg1 === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_strobe", {chg1, chg0}, 80'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("strobe_dut", chg1, e.dut);
        check("strobe_cycle", cyc, e.at);
        check("on_array", chg1 ? on1 : on0, e.on);
        check("burst_data", chg1 ? data1 : data0, e.data);
        check("active_count", chg1 ? cnt1 : cnt0, e.cnt);
      end
    end
  end

  task automatic send(input vec_t v);
    int unsigned a;
    int unsigned n = 0;
    @(negedge clk);
    while (!get_rdy(v.dut) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!get_rdy(v.dut)) begin
      check("ready_timeout", 80'd0, 80'd1);
      return;
    end
    st = v.st; d1 = v.d1; d2 = v.d2;
    if (v.dut) valid1 = 1'b1; else valid0 = 1'b1;
    @(posedge clk);
    #1;
    a = cyc;
    valid0 = 1'b0; valid1 = 1'b0;
    st = 8'hxx; d1 = 8'hxx; d2 = 8'hxx;
    if (v.change) sbq.push_back('{dut: v.dut, on: v.on, data: v.data, cnt: v.cnt, at: a + 1});
    if (!v.change) begin
      wait_to(a + 1);
      check("ready_nochange", get_rdy(v.dut), 80'd1);
    end else if (!v.nowait) begin
      wait_to(a + 33);
      check("ready_in_holdoff", get_rdy(v.dut), 80'd0);
      wait_to(a + 34);
      check("ready_after_holdoff", get_rdy(v.dut), 80'd1);
    end else begin
      wait_to(a + 2);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{0, 8'h90, 8'h3C, 8'h64, 1, 0, 5'b00010, 80'h0000_0000_0000_3C64_0000, 3'd1};
    vt[1]  = '{0, 8'h90, 8'h3E, 8'h64, 1, 0, 5'b00110, 80'h0000_0000_3E64_3C64_0000, 3'd2};
    vt[2]  = '{0, 8'h90, 8'h40, 8'h64, 1, 0, 5'b01110, 80'h0000_4064_3E64_3C64_0000, 3'd3};
    vt[3]  = '{0, 8'h90, 8'h43, 8'h64, 1, 0, 5'b11110, 80'h4364_4064_3E64_3C64_0000, 3'd4};
    vt[4]  = '{0, 8'h90, 8'h45, 8'h50, 1, 0, 5'b11110, 80'h4364_4064_3E64_4550_0000, 3'd4};
    vt[5]  = '{0, 8'h90, 8'h47, 8'h64, 1, 0, 5'b11110, 80'h4364_4064_4764_4550_0000, 3'd4};
    vt[6]  = '{0, 8'hB0, 8'h7B, 8'h00, 1, 0, 5'b00000, 80'h0, 3'd0};
    vt[7]  = '{0, 8'hB0, 8'h7B, 8'h00, 0, 0, 5'b00000, 80'h0, 3'd0};
    vt[8]  = '{0, 8'h90, 8'h3C, 8'h64, 1, 0, 5'b00010, 80'h0000_0000_0000_3C64_0000, 3'd1};
    vt[9]  = '{0, 8'h90, 8'h3C, 8'h00, 1, 0, 5'b00000, 80'h0, 3'd0};
    vt[10] = '{0, 8'h80, 8'h3D, 8'h40, 0, 0, 5'b00000, 80'h0, 3'd0};
    vt[11] = '{0, 8'h90, 8'h3C, 8'h64, 1, 0, 5'b00010, 80'h0000_0000_0000_3C64_0000, 3'd1};
    vt[12] = '{0, 8'h90, 8'h3C, 8'h28, 1, 0, 5'b00010, 80'h0000_0000_0000_3C28_0000, 3'd1};
    vt[13] = '{0, 8'h80, 8'h3C, 8'h00, 1, 0, 5'b00000, 80'h0, 3'd0};
    vt[14] = '{0, 8'hC0, 8'h05, 8'h00, 0, 0, 5'b00000, 80'h0, 3'd0};
    vt[15] = '{0, 8'h90, 8'hBC, 8'hE4, 1, 0, 5'b00010, 80'h0000_0000_0000_3C64_0000, 3'd1};
    vt[16] = '{0, 8'h80, 8'h3C, 8'h40, 1, 0, 5'b00000, 80'h0, 3'd0};
    vt[17] = '{0, 8'h95, 8'h3E, 8'h0A, 1, 0, 5'b00010, 80'h0000_0000_0000_3E0A_0000, 3'd1};
    vt[18] = '{0, 8'h90, 8'h40, 8'h01, 1, 0, 5'b00110, 80'h0000_0000_4001_3E0A_0000, 3'd2};
    vt[19] = '{0, 8'h90, 8'h41, 8'h02, 1, 1, 5'b01110, 80'h0000_4102_4001_3E0A_0000, 3'd3};
    for (int i = 0; i < 5; i++) vt[20 + i] = vt[i];
    vt[25] = '{0, 8'hB0, 8'h7B, 8'h00, 1, 0, 5'b00000, 80'h0, 3'd0};
    vt[26] = '{0, 8'h90, 8'h3C, 8'h00, 0, 0, 5'b00000, 80'h0, 3'd0};
    vt[27] = '{1, 8'h93, 8'h3C, 8'h64, 0, 0, 5'b00000, 80'h0, 3'd0};
    vt[28] = '{1, 8'h92, 8'h3C, 8'h64, 1, 0, 5'b00010, 80'h0000_0000_0000_3C64_0000, 3'd1};
    vt[29] = '{1, 8'hB2, 8'h7B, 8'h00, 1, 0, 5'b00000, 80'h0, 3'd0};
    vt[30] = '{1, 8'hB2, 8'h7B, 8'h00, 0, 0, 5'b00000, 80'h0, 3'd0};

    rst = 1'b1; valid0 = 1'b0; valid1 = 1'b0;
    st = 8'h00; d1 = 8'h00; d2 = 8'h00;
    repeat (3) @(negedge clk);
    check("ready_during_reset", rdy0, 80'd0);
    check("reset_on_array", on0, 80'd0);
    check("reset_data", data0, 80'd0);
    check("reset_count", cnt0, 80'd0);
    check("reset_strobe", chg0, 80'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", rdy0, 80'd1);
    check("ready_after_reset_ch", rdy1, 80'd1);

    for (int i = 0; i < 20; i++) send(vt[i]);

    // Reset lands in HOLDOFF with three slots on.
    rst = 1'b1;
    @(negedge clk);
    check("midrst_on_array", on0, 80'd0);
    check("midrst_data", data0, 80'd0);
    check("midrst_count", cnt0, 80'd0);
    check("midrst_strobe", chg0, 80'd0);
    check("midrst_ready_low", rdy0, 80'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_high", rdy0, 80'd1);
    check("midrst_strobe_after", chg0, 80'd0);

    for (int i = 20; i < 31; i++) send(vt[i]);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 80'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
